// File: rtl/timer_irq_dev.sv
// Memory-mapped countdown timer with a maskable interrupt request.
// Software sets CTRL (En/Mode/IM) and PRESET; COUNT is read-only.
module timer_irq_dev (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CNT  = 2'd1,
        INT  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_en;
    logic [1:0]  r_mode;
    logic        r_im;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_pend;

    logic        w_wrCtrl;
    logic        w_wrPreset;
    logic        w_ack;
    logic        w_expire;
    logic        w_autoReload;

    assign w_wrCtrl     = we && (addr == 2'd0);
    assign w_wrPreset   = we && (addr == 2'd1);
    assign w_ack        = w_wrCtrl || w_wrPreset;
    assign w_expire     = (r_state == CNT) && r_en && (r_count <= 32'd1);
    assign w_autoReload = (r_mode == 2'd1);

    // Bus writes take priority over the FSM's own En clear, but an expiry
    // on the same edge as an acknowledge still leaves the request pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_en     <= 1'b0;
            r_mode   <= 2'd0;
            r_im     <= 1'b0;
            r_preset <= 32'd0;
            r_count  <= 32'd0;
            r_pend   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_en) begin
                        r_count <= r_preset;
                        r_state <= CNT;
                    end
                end
                CNT: begin
                    if (!r_en) begin
                        r_state <= IDLE;
                    end else if (r_count > 32'd1) begin
                        r_count <= r_count - 32'd1;
                    end else begin
                        r_count <= 32'd0;
                        r_state <= INT;
                    end
                end
                INT: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            if (w_wrCtrl) begin
                r_en   <= din[0];
                r_mode <= din[2:1];
                r_im   <= din[3];
            end else if ((r_state == INT) && !w_autoReload) begin
                r_en <= 1'b0;
            end

            if (w_wrPreset) begin
                r_preset <= din;
            end

            if (w_expire) begin
                r_pend <= 1'b1;
            end else if (w_ack || ((r_state == INT) && w_autoReload)) begin
                r_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        dout = 32'd0;
        case (addr)
            2'd0:    dout = {28'd0, r_im, r_mode, r_en};
            2'd1:    dout = r_preset;
            2'd2:    dout = r_count;
            default: dout = 32'd0;
        endcase
    end

    assign irq = r_im && r_pend;

endmodule
